// File: rtl/ctrl_input_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_input_decoder: resistor-ladder key decoder, debounce + auto-repeat  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ctrl_input_decoder #(
  parameter int   DEBOUNCE_CYCLES = 250000,
  parameter int   REPEAT_DELAY    = 12500000,
  parameter int   REPEAT_PERIOD   = 2500000,
  parameter logic KEY_PRESS       = 1'b1
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic [1:0] raw_x,
  input  logic [1:0] raw_y,
  input  logic       rpt_en,
  output logic       one_resistor_x,
  output logic       two_resistors_x,
  output logic       one_resistor_y,
  output logic       two_resistors_y,
  output logic       key_evt_x,
  output logic       key_evt_y
);

  localparam int c_DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_RD_W  = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam int c_RP_W  = (REPEAT_PERIOD > 1) ? $clog2(REPEAT_PERIOD) : 1;
  localparam int c_RPT_W = (c_RD_W > c_RP_W) ? c_RD_W : c_RP_W;

  localparam logic [c_DB_W-1:0]  c_DB_MAX = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_RPT_W-1:0] c_RD_MAX = c_RPT_W'(REPEAT_DELAY - 1);
  localparam logic [c_RPT_W-1:0] c_RP_MAX = c_RPT_W'(REPEAT_PERIOD - 1);

  localparam logic [1:0] c_CODE_NONE = 2'b00;
  localparam logic [1:0] c_CODE_ONE  = 2'b01;
  localparam logic [1:0] c_CODE_TWO  = 2'b11;
  localparam logic [1:0] c_CODE_BAD  = 2'b10;

  typedef enum logic [1:0] {
    S_RELEASED   = 2'd0,
    S_HOLD_DELAY = 2'd1,
    S_HOLD_RPT   = 2'd2
  } state_t;

  for (genvar a = 0; a < 2; a++) begin : g_axis
    logic [1:0]         w_raw;
    logic               w_accept;
    logic [1:0]         r_sync1;
    logic [1:0]         r_sync2;
    logic [1:0]         r_cand;
    logic [1:0]         r_acc;
    logic [c_DB_W-1:0]  r_db_cnt;
    logic [c_RPT_W-1:0] r_rpt_cnt;
    state_t             r_state;
    logic               r_one;
    logic               r_two;
    logic               r_evt;

    assign w_raw = (a == 0) ? raw_x : raw_y;

    // The invalid code 10 may become the candidate but is never promoted.
    assign w_accept = (r_db_cnt == c_DB_MAX) && (r_sync2 == r_cand) &&
                      (r_cand != c_CODE_BAD) && (r_cand != r_acc);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        r_sync1   <= c_CODE_NONE;
        r_sync2   <= c_CODE_NONE;
        r_cand    <= c_CODE_NONE;
        r_acc     <= c_CODE_NONE;
        r_db_cnt  <= '0;
        r_rpt_cnt <= '0;
        r_state   <= S_RELEASED;
        r_one     <= ~KEY_PRESS;
        r_two     <= ~KEY_PRESS;
        r_evt     <= 1'b0;
      end else begin
        r_sync1 <= w_raw;
        r_sync2 <= r_sync1;

        if (r_sync2 != r_cand) begin
          r_cand   <= r_sync2;
          r_db_cnt <= '0;
        end else if (r_db_cnt != c_DB_MAX) begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end

        r_evt <= 1'b0;
        // Acceptance outranks any repeat boundary, so a release never pulses.
        if (w_accept) begin
          r_acc     <= r_cand;
          r_one     <= (r_cand == c_CODE_ONE) ? KEY_PRESS : ~KEY_PRESS;
          r_two     <= (r_cand == c_CODE_TWO) ? KEY_PRESS : ~KEY_PRESS;
          r_rpt_cnt <= '0;
          if (r_cand == c_CODE_NONE) begin
            r_state <= S_RELEASED;
          end else begin
            r_state <= S_HOLD_DELAY;
            r_evt   <= 1'b1;
          end
        end else if (rpt_en) begin
          case (r_state)
            S_HOLD_DELAY: begin
              if (r_rpt_cnt == c_RD_MAX) begin
                r_rpt_cnt <= '0;
                r_evt     <= 1'b1;
                r_state   <= S_HOLD_RPT;
              end else begin
                r_rpt_cnt <= r_rpt_cnt + 1'b1;
              end
            end
            S_HOLD_RPT: begin
              if (r_rpt_cnt == c_RP_MAX) begin
                r_rpt_cnt <= '0;
                r_evt     <= 1'b1;
              end else begin
                r_rpt_cnt <= r_rpt_cnt + 1'b1;
              end
            end
            S_RELEASED: begin
              r_rpt_cnt <= '0;
            end
            default: begin
              r_rpt_cnt <= '0;
              r_state   <= S_RELEASED;
            end
          endcase
        end
      end
    end
  end

  assign one_resistor_x  = g_axis[0].r_one;
  assign two_resistors_x = g_axis[0].r_two;
  assign key_evt_x       = g_axis[0].r_evt;
  assign one_resistor_y  = g_axis[1].r_one;
  assign two_resistors_y = g_axis[1].r_two;
  assign key_evt_y       = g_axis[1].r_evt;

endmodule
`default_nettype wire
